// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU mode and state encodings.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ADC = 2'b10;
  localparam logic [1:0] MODE_SBB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Subtracts add ~B + 1; the carry-chaining modes take the caller's carry instead.
  function automatic logic init_carry(input logic [1:0] mode, input logic cin);
    logic c;
    case (mode)
      MODE_ADD: c = 1'b0;
      MODE_SUB: c = 1'b1;
      default:  c = cin;
    endcase
    return c;
  endfunction

  function automatic logic is_subtract(input logic [1:0] mode);
    return (mode == MODE_SUB) || (mode == MODE_SBB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_adder.sv
// ============================================================================
// Module      : chunk_adder
// Description : CHUNK-bit combinational adder with carry out and carry into MSB.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum    = w_full[CHUNK-1:0];
  assign cout   = w_full[CHUNK];
  // The top sum bit is a^b^carry_in, so the carry into it can be recovered.
  assign c_msb  = w_full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/add_sub_seq.sv
// ============================================================================
// Module      : add_sub_seq
// Description : Multi-cycle chunked add/subtract unit with ZCVN flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module add_sub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;

  logic [CHUNK-1:0] w_a_chunk, w_b_chunk, w_sum;
  logic             w_cout, w_c_msb;

  assign w_a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign w_b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (w_a_chunk),
    .b     (w_b_chunk),
    .cin   (c_q),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    shadow_d = shadow_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          a_d     = inA;
          b_d     = is_subtract(mode) ? ~inB : inB;
          c_d     = init_carry(mode, cin);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        shadow_d[idx_q*CHUNK +: CHUNK] = w_sum;
        c_d = w_cout;
        if (idx_q == IDX_LAST) begin
          // Visible outputs move only here, so they stay stable between done pulses.
          state_d  = ST_DONE;
          result_d = shadow_d;
          zero_d   = (shadow_d == '0);
          carry_d  = w_cout;
          ovf_d    = w_cout ^ w_c_msb;
          neg_d    = shadow_d[WIDTH-1];
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      shadow_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign negative = neg_q;

endmodule

`default_nettype wire
